switch_xbar: RTL and testbench

SWITCH_XBAR -- requirements
Module: switch_xbar

---
 rtl/switch_xbar.sv | 165 ++++++++++++++++
 tb/tb_switch_xbar.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_xbar.sv
// switch_xbar: NUM_PORTS x NUM_PORTS flit crossbar with multicast, one-entry
// output registers and a rotating-priority grant pass.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - per-input flit present
//   in_data    - per-input flit, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl    - per-input destination mask, input i at [i*NUM_PORTS +: NUM_PORTS]
//   in_ready   - combinational: input i's flit is consumed this cycle
//   out_valid  - per-output flit valid (registered)
//   out_data   - per-output flit (registered), sliced as in_data
//   out_ready  - downstream accepts output j this cycle
//   drop_cnt   - count of consumed zero-mask flits (saturating)
//
// Build option: define SWITCH_XBAR_DROP_CNT_EN to enable the drop counter;
// otherwise drop_cnt is tied to zero.

module switch_xbar #(
    parameter int unsigned NUM_PORTS  = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_ctrl,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [NUM_PORTS-1:0]  mask [NUM_PORTS];
    logic [DATA_WIDTH-1:0] din  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  free;
    logic [NUM_PORTS-1:0]  grant;
    logic [NUM_PORTS-1:0]  drop;
    logic [NUM_PORTS-1:0]  claimed;
    logic [NUM_PORTS-1:0]  load;
    logic [DATA_WIDTH-1:0] load_data [NUM_PORTS];
    logic [SUM_W-1:0]      arb_pos;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_found;

    // Unpack the flattened input buses into per-input masks and payloads.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            mask[i] = in_ctrl[i*NUM_PORTS +: NUM_PORTS];
            din[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // An output register can take a new flit if empty or draining this cycle.
    assign free = ~out_valid | out_ready;

    // Grant pass in rotating order starting at ptr. A multicast flit is
    // granted only when every target is free and unclaimed, which makes the
    // write atomic across its whole mask.
    always_comb begin
        grant     = '0;
        drop      = '0;
        claimed   = '0;
        ptr_next  = ptr;
        arb_found = 1'b0;
        arb_pos   = '0;
        arb_idx   = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            arb_pos = SUM_W'(ptr) + SUM_W'(k);
            if (arb_pos >= SUM_W'(NUM_PORTS)) begin
                arb_pos = arb_pos - SUM_W'(NUM_PORTS);
            end
            arb_idx = PTR_W'(arb_pos);
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (arb_idx == PTR_W'(i) && in_valid[i]) begin
                    if (mask[i] == '0) begin
                        // Zero-mask flits are swallowed and leave ptr alone.
                        drop[i] = 1'b1;
                    end else if (((mask[i] & ~free) == '0) &&
                                 ((mask[i] & claimed) == '0)) begin
                        grant[i] = 1'b1;
                        claimed  = claimed | mask[i];
                        if (!arb_found) begin
                            arb_found = 1'b1;
                            ptr_next  = (i == int'(NUM_PORTS) - 1) ? '0 : PTR_W'(i + 1);
                        end
                    end
                end
            end
        end
    end

    assign in_ready = rst ? '0 : (grant | drop);

    // Route each granted payload to the outputs named in its mask; masks of
    // granted inputs never overlap, so at most one source drives an output.
    always_comb begin
        load = '0;
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            load_data[j] = '0;
        end
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            for (int j = 0; j < int'(NUM_PORTS); j++) begin
                if (grant[i] && mask[i][j]) begin
                    load[j]      = 1'b1;
                    load_data[j] = din[i];
                end
            end
        end
    end

    // Output registers and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            ptr <= ptr_next;
            for (int j = 0; j < int'(NUM_PORTS); j++) begin
                if (load[j]) begin
                    out_valid[j]                          <= 1'b1;
                    out_data[j*DATA_WIDTH +: DATA_WIDTH] <= load_data[j];
                end else if (out_ready[j]) begin
                    out_valid[j] <= 1'b0;
                end
            end
        end
    end

`ifdef SWITCH_XBAR_DROP_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [SUM_W-1:0] drop_num;
    logic [CNT_W:0]   drop_sum;

    // Number of zero-mask flits consumed this cycle, added with saturation.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            drop_num = drop_num + SUM_W'(drop[i]);
        end
        drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_num);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_sum[CNT_W]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[CNT_W-1:0];
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_xbar.sv
// Directed scoreboard bench for switch_xbar: stimulus pushes expected flits
// into per-output queues, a monitor pops them on every output handshake.

module tb_switch_xbar;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N*N-1:0]  in_ctrl;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    out_valid;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_ready;
    logic [15:0]     drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [N][$];

`ifdef SWITCH_XBAR_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd3;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    switch_xbar #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int i, input logic v, input logic [N-1:0] m, input logic [DW-1:0] d);
        in_valid[i]          = v;
        in_ctrl[i*N +: N]    = m;
        in_data[i*DW +: DW]  = d;
    endtask

    task automatic push(input logic [N-1:0] m, input logic [DW-1:0] d);
        for (int j = 0; j < int'(N); j++) begin
            if (m[j]) exp_q[j].push_back(d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the head of its queue.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int j = 0; j < int'(N); j++) begin
                    if (out_valid[j] && out_ready[j]) begin
                        if (exp_q[j].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected flit on out %0d: got %0h expected none",
                                     j, out_data[j*DW +: DW]);
                        end else begin
                            e = exp_q[j].pop_front();
                            chk($sformatf("out_data[%0d]", j), N*DW'(out_data[j*DW +: DW]), N*DW'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset with live inputs: nothing may be consumed.
        rst       = 1'b1;
        out_ready = '1;
        in_valid  = '0;
        in_data   = '0;
        in_ctrl   = '0;
        for (int i = 0; i < int'(N); i++) set_in(i, 1'b1, N'(1 << i), DW'(32'hDEAD_0000 + i));
        @(negedge clk);
        chk("in_ready during reset", N*DW'(in_ready), '0);
        step();
        step();
        in_valid = '0;
        rst      = 1'b0;
        @(negedge clk);
        chk("reset out_valid", N*DW'(out_valid), '0);
        chk("reset out_data", out_data, '0);
        chk("reset drop_cnt", N*DW'(drop_cnt), '0);
        chk("reset ptr", N*DW'(dut.ptr), '0);

        // Unicast input 1 -> output 0.
        step();
        set_in(1, 1'b1, 5'b00001, 32'hA5A5_0001);
        @(negedge clk);
        chk("unicast in_ready", N*DW'(in_ready), N*DW'(5'b00010));
        push(5'b00001, 32'hA5A5_0001);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("unicast out_valid", N*DW'(out_valid), N*DW'(5'b00001));

        // Park a flit on output 3 under backpressure (ptr 2 -> 4).
        step();
        out_ready = 5'b10111;
        set_in(3, 1'b1, 5'b01000, 32'h3333_0003);
        @(negedge clk);
        chk("park out3 in_ready", N*DW'(in_ready), N*DW'(5'b01000));
        push(5'b01000, 32'h3333_0003);
        step();
        in_valid = '0;
        set_in(0, 1'b1, 5'b11110, 32'hC0C0_0000);
        @(negedge clk);
        chk("mcast blocked in_ready", N*DW'(in_ready), '0);
        chk("mcast blocked out_valid", N*DW'(out_valid), N*DW'(5'b01000));
        step();
        @(negedge clk);
        chk("mcast still blocked", N*DW'(in_ready), '0);
        chk("held out_data[3]", N*DW'(out_data[3*DW +: DW]), N*DW'(32'h3333_0003));
        step();
        out_ready = '1;
        @(negedge clk);
        chk("mcast grant in_ready", N*DW'(in_ready), N*DW'(5'b00001));
        push(5'b11110, 32'hC0C0_0000);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("mcast out_valid", N*DW'(out_valid), N*DW'(5'b11110));

        // Move ptr to 0 with a grant on input 4 (ptr 1 -> 0).
        step();
        set_in(4, 1'b1, 5'b10000, 32'h4444_0004);
        @(negedge clk);
        chk("ptr setup in_ready", N*DW'(in_ready), N*DW'(5'b10000));
        push(5'b10000, 32'h4444_0004);

        // Conflict fairness: inputs 1 and 2 both target output 0.
        step();
        in_valid = '0;
        chk("fair start ptr", N*DW'(dut.ptr), '0);
        set_in(1, 1'b1, 5'b00001, 32'h1111_0001);
        set_in(2, 1'b1, 5'b00001, 32'h2222_0002);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                chk($sformatf("fair grant %0d", c), N*DW'(in_ready), N*DW'(5'b00010));
                push(5'b00001, 32'h1111_0001);
            end else begin
                chk($sformatf("fair grant %0d", c), N*DW'(in_ready), N*DW'(5'b00100));
                push(5'b00001, 32'h2222_0002);
            end
            step();
        end
        in_valid = '0;

        // Input 3 alone moves ptr 3 -> 4, then a disjoint pair wraps it to 0.
        set_in(3, 1'b1, 5'b01000, 32'h3333_1003);
        @(negedge clk);
        chk("ptr to 4 in_ready", N*DW'(in_ready), N*DW'(5'b01000));
        push(5'b01000, 32'h3333_1003);
        step();
        set_in(3, 1'b1, 5'b00100, 32'h3333_2003);
        set_in(4, 1'b1, 5'b00010, 32'h4444_2004);
        @(negedge clk);
        chk("disjoint in_ready", N*DW'(in_ready), N*DW'(5'b11000));
        push(5'b00100, 32'h3333_2003);
        push(5'b00010, 32'h4444_2004);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("disjoint ptr wrap", N*DW'(dut.ptr), '0);
        chk("disjoint out_valid", N*DW'(out_valid), N*DW'(5'b00110));

        // Zero-mask drops on input 2 for three cycles.
        step();
        set_in(2, 1'b1, 5'b00000, 32'hBAD0_0002);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("drop in_ready %0d", c), N*DW'(in_ready), N*DW'(5'b00100));
            step();
        end
        in_valid = '0;
        @(negedge clk);
        chk("drop out_valid", N*DW'(out_valid), '0);
        chk("drop_cnt", N*DW'(drop_cnt), N*DW'(EXP_DROP));
        chk("drop ptr unchanged", N*DW'(dut.ptr), '0);

        // Reset mid-transfer with three stalled outputs.
        step();
        out_ready = '0;
        set_in(0, 1'b1, 5'b00001, 32'hF000_0000);
        set_in(2, 1'b1, 5'b00100, 32'hF000_0002);
        set_in(4, 1'b1, 5'b10000, 32'hF000_0004);
        @(negedge clk);
        chk("stall load in_ready", N*DW'(in_ready), N*DW'(5'b10101));
        step();
        in_valid = '0;
        @(negedge clk);
        chk("stall out_valid", N*DW'(out_valid), N*DW'(5'b10101));
        step();
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) set_in(i, 1'b1, N'(1 << i), DW'(32'hE000_0000 + i));
        @(negedge clk);
        chk("in_ready in mid reset", N*DW'(in_ready), '0);
        step();
        rst       = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        @(negedge clk);
        chk("mid reset out_valid", N*DW'(out_valid), '0);
        chk("mid reset out_data", out_data, '0);
        chk("mid reset ptr", N*DW'(dut.ptr), '0);
        chk("mid reset drop_cnt", N*DW'(drop_cnt), '0);

        step();
        step();
        for (int j = 0; j < int'(N); j++) begin
            chk($sformatf("queue %0d drained", j), N*DW'(exp_q[j].size()), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
